// File: rtl/imem_loader.sv
// Serial instruction-memory loader: assembles big-endian bytes into 32-bit words
// and writes them to consecutive word-aligned addresses, one write per word.
module imem_loader #(
    parameter int n         = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] base_addr,
    input  logic [10:0]  word_count,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic         wr_en,
    output logic [n-1:0] wr_addr,
    output logic [n-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [10:0] MAX_WC = 11'(MAX_WORDS);

    state_t       state;
    state_t       state_nxt;
    logic [n-1:0] ptr;
    logic [23:0]  sr;
    logic [n-1:0] wr_data_q;
    logic [1:0]   byte_cnt;
    logic [10:0]  words_done;
    logic [10:0]  count_lat;
    logic [10:0]  wc_clamped;
    logic         accept;
    logic         last_word;

    // Byte handshake: a byte transfers on a rising edge where byte_valid and
    // byte_ready are both high; byte_ready depends on state only, never on byte_valid.
    assign accept     = byte_valid && (state == RECV);
    assign wc_clamped = (word_count > MAX_WC) ? MAX_WC : word_count;
    assign last_word  = ((words_done + 11'd1) == count_lat);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (word_count == 11'd0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (accept && (byte_cnt == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = last_word ? DONE : RECV;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: pointer, counters and byte assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            sr         <= '0;
            wr_data_q  <= '0;
            byte_cnt   <= '0;
            words_done <= '0;
            count_lat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (word_count != 11'd0)) begin
                        ptr        <= base_addr & ~n'(3);
                        count_lat  <= wc_clamped;
                        byte_cnt   <= '0;
                        words_done <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        sr       <= {sr[15:0], byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                        // The fourth byte completes the word; capture it for the write cycle.
                        if (byte_cnt == 2'd3) begin
                            wr_data_q <= {sr, byte_in};
                        end
                    end
                end
                WRITE: begin
                    ptr        <= ptr + n'(4);
                    words_done <= words_done + 11'd1;
                    byte_cnt   <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE:    busy       = 1'b0;
            RECV:    byte_ready = 1'b1;
            WRITE:   wr_en      = 1'b1;
            DONE:    done       = 1'b1;
            default: busy       = 1'b0;
        endcase
    end

    assign wr_addr   = ptr;
    assign wr_data   = wr_data_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a per-cycle vector table for the short sequences, plus
// a scripted load task with a scoreboard queue for the multi-word cases.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [10:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];

    imem_loader #(.n(32), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic [31:0] base;
        logic [10:0] wc;
        logic [7:0]  bin;
        logic        bv;
        logic        e_wr_en;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic        e_br;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [31:0] b,
                                input logic [10:0] w, input logic [7:0] bi, input logic bv,
                                input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                                input logic eb, input logic edn, input logic er,
                                input logic [1:0] es);
        vec_t v;
        v.rst = r; v.start = s; v.base = b; v.wc = w; v.bin = bi; v.bv = bv;
        v.e_wr_en = ew; v.e_addr = ea; v.e_data = ed; v.e_busy = eb;
        v.e_done = edn; v.e_br = er; v.e_state = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        byte_in = '0; byte_valid = 1'b0;
    endtask

    // Drive one vector at a negedge, let one rising edge pass, compare at the next negedge.
    task automatic apply_vec(input int i, input vec_t v);
        rst = v.rst; start = v.start; base_addr = v.base; word_count = v.wc;
        byte_in = v.bin; byte_valid = v.bv;
        @(negedge clk);
        check($sformatf("v%0d.wr_en", i), 32'(wr_en), 32'(v.e_wr_en));
        check($sformatf("v%0d.wr_data", i), wr_data, v.e_data);
        check($sformatf("v%0d.busy", i), 32'(busy), 32'(v.e_busy));
        check($sformatf("v%0d.done", i), 32'(done), 32'(v.e_done));
        check($sformatf("v%0d.byte_ready", i), 32'(byte_ready), 32'(v.e_br));
        check($sformatf("v%0d.state", i), 32'(state_dbg), 32'(v.e_state));
        if (v.e_wr_en || v.rst) begin
            check($sformatf("v%0d.wr_addr", i), wr_addr, v.e_addr);
        end
    endtask

    // Full load with random payload; gap is the percent chance of a byte_valid bubble,
    // poke pulses start at random while busy to prove it is ignored.
    task automatic run_load(input string name, input logic [31:0] base, input logic [10:0] wc,
                            input int gap, input bit poke);
        logic [7:0]  bq[$];
        logic [31:0] addr;
        logic [31:0] word;
        int          nw;
        int          bi;
        int          cycles;
        int          done_cnt;
        int          wr_cnt;
        logic        rdy;
        logic [63:0] e;

        nw   = (wc > 11'd1024) ? 1024 : int'(wc);
        addr = {base[31:2], 2'b00};
        bq.delete();
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            word = $urandom;
            bq.push_back(word[31:24]);
            bq.push_back(word[23:16]);
            bq.push_back(word[15:8]);
            bq.push_back(word[7:0]);
            exp_q.push_back({addr, word});
            addr = addr + 32'd4;
        end

        start = 1'b1; base_addr = base; word_count = wc; byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        bi = 0; cycles = 0; done_cnt = 0; wr_cnt = 0;
        while (cycles < 20000) begin
            if (wr_en) begin
                wr_cnt++;
                check({name, ".ready_in_write"}, 32'(byte_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    check({name, ".extra_write"}, 32'(wr_cnt), 32'(nw));
                end else begin
                    e = exp_q.pop_front();
                    check({name, ".wr_addr"}, wr_addr, e[63:32]);
                    check({name, ".wr_data"}, wr_data, e[31:0]);
                end
            end
            if (done) begin
                done_cnt++;
                break;
            end
            byte_valid = (bi < bq.size()) && ($urandom_range(0, 99) >= gap);
            byte_in    = byte_valid ? bq[bi] : 8'h5A;
            start      = poke && ($urandom_range(0, 3) == 0);
            base_addr  = $urandom;
            word_count = 11'd1;
            rdy        = byte_ready;
            @(posedge clk);
            if (byte_valid && rdy) bi++;
            @(negedge clk);
            cycles++;
        end
        idle_inputs();
        check({name, ".done_seen"}, 32'(done_cnt), 32'd1);
        check({name, ".writes"}, 32'(wr_cnt), 32'(nw));
        check({name, ".bytes_used"}, 32'(bi), 32'(bq.size()));
        check({name, ".queue_left"}, 32'(exp_q.size()), 32'd0);
        if (gap == 0) begin
            check({name, ".cycles"}, 32'(cycles), 32'(5 * nw));
        end
        @(negedge clk);
        check({name, ".busy_after"}, 32'(busy), 32'd0);
        check({name, ".done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);

        //          rst  st  base           wc      byte   bv   wr  addr           data           busy done br  state
        tbl.push_back(mk(1, 0, 32'h0,        11'd0, 8'h00, 0,   0, 32'h0,        32'h0,         0, 0, 0, 2'd0));
        tbl.push_back(mk(0, 1, 32'h0,        11'd1, 8'h00, 0,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h20, 1,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h08, 1,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'hFF, 0,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h00, 1,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h05, 1,   1, 32'h0,        32'h20080005,  1, 0, 0, 2'd2));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h99, 1,   0, 32'h0,        32'h20080005,  1, 1, 0, 2'd3));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h00, 0,   0, 32'h0,        32'h20080005,  0, 0, 0, 2'd0));
        // Zero-length load: straight to DONE, no bytes taken
        tbl.push_back(mk(0, 1, 32'h100,      11'd0, 8'h77, 1,   0, 32'h0,        32'h20080005,  1, 1, 0, 2'd3));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h77, 1,   0, 32'h0,        32'h20080005,  0, 0, 0, 2'd0));
        // Reset mid-word, with start raised in the reset cycle
        tbl.push_back(mk(0, 1, 32'h80,       11'd1, 8'h00, 0,   0, 32'h0,        32'h20080005,  1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h11, 1,   0, 32'h0,        32'h20080005,  1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h22, 1,   0, 32'h0,        32'h20080005,  1, 0, 1, 2'd1));
        tbl.push_back(mk(1, 1, 32'h80,       11'd1, 8'h33, 1,   0, 32'h0,        32'h0,         0, 0, 0, 2'd0));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h44, 1,   0, 32'h0,        32'h0,         0, 0, 0, 2'd0));
        // Fresh load from an unaligned base
        tbl.push_back(mk(0, 1, 32'h13,       11'd1, 8'h00, 0,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'hAA, 1,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'hBB, 1,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'hCC, 1,   0, 32'h0,        32'h0,         1, 0, 1, 2'd1));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'hDD, 1,   1, 32'h10,       32'hAABBCCDD,  1, 0, 0, 2'd2));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'hEE, 1,   0, 32'h0,        32'hAABBCCDD,  1, 1, 0, 2'd3));
        tbl.push_back(mk(0, 0, 32'h0,        11'd0, 8'h00, 0,   0, 32'h0,        32'hAABBCCDD,  0, 0, 0, 2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(i, tbl[i]);
        end
        idle_inputs();
        @(negedge clk);

        run_load("gaps3",   32'h00000040, 11'd3,    40, 1'b0);
        run_load("wrap",    32'hFFFFFFFD, 11'd2,    0,  1'b0);
        run_load("poke",    32'h00000200, 11'd4,    30, 1'b1);
        run_load("clamp",   32'h00001000, 11'd2047, 0,  1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
